// File: rtl/lane_map_reader_if.sv
// lane_map_reader_if: BRAM read port and packed-word output stream of the lane-map reader
interface lane_map_reader_if #(
    parameter int AW = 11
) ();
    logic          bram_rd_en;
    logic [AW-1:0] bram_rd_addr;
    logic [7:0]    bram_rd_data;
    logic [31:0]   o_data;
    logic          o_valid;
    logic          o_last;
    logic          i_ready;

    modport master (
        output bram_rd_en, bram_rd_addr, o_data, o_valid, o_last,
        input  bram_rd_data, i_ready
    );

    modport slave (
        input  bram_rd_en, bram_rd_addr, o_data, o_valid, o_last,
        output bram_rd_data, i_ready
    );
endinterface

// File: rtl/lane_map_reader.sv
// lane_map_reader: sweeps the finished lane-map BRAM and streams it out as packed 32-bit words
module lane_map_reader #(
    parameter int OUT_WIDTH  = 64,
    parameter int OUT_HEIGHT = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_frame_valid,
    lane_map_reader_if.master bus,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_abort
);
    localparam int N  = OUT_WIDTH * OUT_HEIGHT;
    localparam int AW = $clog2(N);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]    state;
    logic          fv_q;
    logic [AW-1:0] addr;
    logic          rd_v;
    logic          rd_b3;
    logic          rd_last;
    logic [23:0]   pk;
    logic [32:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] cnt;
    logic [CW:0]   committed;
    logic          start;
    logic          abort;
    logic          rd_en;
    logic          push;
    logic          pop;
    logic          at_end;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(FIFO_DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign bus.bram_rd_en   = rd_en;
    assign bus.bram_rd_addr = addr;
    assign bus.o_valid      = cnt != '0;
    assign bus.o_data       = bus.o_valid ? mem[rp][31:0] : '0;
    assign bus.o_last       = bus.o_valid && mem[rp][32];
    assign o_busy           = state != IDLE;

    // A byte-3 read may only go out if its word will have a FIFO slot reserved on return
    always_comb begin
        abort     = state != IDLE && !i_frame_valid;
        start     = state == IDLE && i_frame_valid && !fv_q;
        at_end    = addr == AW'(N - 1);
        committed = (CW+1)'(cnt) + (CW+1)'(rd_v && rd_b3);
        rd_en     = state == READ && i_frame_valid && (addr[1:0] != 2'd3 || committed < (CW+1)'(FIFO_DEPTH));
        push      = rd_v && rd_b3;
        pop       = bus.o_valid && bus.i_ready;
    end

    // Sweep control; fv_q resets high so a level already present at reset release is not a new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            fv_q         <= 1'b1;
            addr         <= '0;
            o_frame_done <= 1'b0;
            o_abort      <= 1'b0;
        end else begin
            fv_q         <= i_frame_valid;
            o_abort      <= abort;
            o_frame_done <= !abort && state == DRAIN && pop && bus.o_last;
            if (abort) begin
                state <= IDLE;
            end else if (start) begin
                state <= READ;
                addr  <= '0;
            end else if (rd_en) begin
                if (at_end)
                    state <= DRAIN;
                else
                    addr <= addr + AW'(1);
            end else if (state == DRAIN && pop && bus.o_last) begin
                state <= IDLE;
            end
        end
    end

    // Byte packing and output word FIFO; an abort discards in-flight data and flushes the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v    <= 1'b0;
            rd_b3   <= 1'b0;
            rd_last <= 1'b0;
            pk      <= '0;
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            rd_v    <= rd_en;
            rd_b3   <= addr[1:0] == 2'd3;
            rd_last <= at_end;
            if (abort) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (rd_v && !push)
                    pk <= {bus.bram_rd_data, pk[23:8]};
                if (push) begin
                    mem[wp] <= {rd_last, bus.bram_rd_data, pk};
                    wp      <= nxt(wp);
                end
                if (pop)
                    rp <= nxt(rp);
                cnt <= cnt + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_lane_map_reader.sv
// tb_lane_map_reader: directed frame vectors plus reset/hold corner sequences for lane_map_reader
module tb_lane_map_reader;
    localparam int N     = 2048;
    localparam int AW    = 11;
    localparam int DEPTH = 2;

    typedef struct {
        int          mode;
        int          abort_at;
        int          salt;
        int          words;
        logic [31:0] w0;
        logic [31:0] wl;
        int          dones;
        int          aborts;
        int          reads;
        int          stall_addr;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic fv    = 1'b0;
    logic busy;
    logic done;
    logic abrt;
    int   salt     = 0;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs [5];

    lane_map_reader_if #(.AW(AW)) bus ();

    lane_map_reader #(.OUT_WIDTH(64), .OUT_HEIGHT(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_frame_valid(fv),
        .bus          (bus),
        .o_busy       (busy),
        .o_frame_done (done),
        .o_abort      (abrt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bbyte(input int a);
        return 8'(a + salt * (a >> 8));
    endfunction

    function automatic logic [31:0] word(input int w);
        return {bbyte(4 * w + 3), bbyte(4 * w + 2), bbyte(4 * w + 1), bbyte(4 * w)};
    endfunction

    function automatic logic [63:0] outs();
        return {15'b0, bus.bram_rd_en, bus.bram_rd_addr, bus.o_data, bus.o_valid, bus.o_last, busy, done, abrt};
    endfunction

    always @(posedge clk)
        if (bus.bram_rd_en)
            bus.bram_rd_data <= bbyte(int'(bus.bram_rd_addr));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t        v;
        int          cyc = 0, words = 0, dones = 0, aborts = 0, reads = 0, exp_addr = 0;
        int          aerr = 0, derr = 0, serr = 0, cerr = 0, b3 = 0;
        int          lat = -1, last_hs = -100, gap = -1, stall_left = 0, stall_max = -1;
        int          tail = -1, abort_cyc = -1;
        bit          stalled = 1'b0, pv = 1'b0, hs;
        logic [31:0] pd = '0, w0 = '0, wl = '0;
        logic        pl = 1'b0;
        v = vecs[i];
        salt = v.salt;
        fv = 1'b0;
        bus.i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 fv = 1'b1;
        while (cyc < 12000 && tail != 0) begin
            @(negedge clk);
            hs = bus.o_valid && bus.i_ready;
            if (bus.o_valid && lat < 0) lat = cyc;
            if (pv && !(bus.o_valid && bus.o_data === pd && bus.o_last === pl)) serr++;
            pv = bus.o_valid && !bus.i_ready;
            pd = bus.o_data;
            pl = bus.o_last;
            if (bus.bram_rd_en) begin
                if (int'(bus.bram_rd_addr) != exp_addr) aerr++;
                if (bus.bram_rd_addr[1:0] == 2'd3) begin
                    b3++;
                    if (b3 - words > DEPTH) cerr++;
                end
                if (v.mode == 1 && !bus.i_ready) stall_max = int'(bus.bram_rd_addr);
                exp_addr++;
                reads++;
            end
            if (done) begin
                dones++;
                gap = cyc - last_hs;
            end
            if (abrt) aborts++;
            if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
                check($sformatf("v%0d_abort_pulse", i), abrt, 1);
                check($sformatf("v%0d_abort_valid_low", i), bus.o_valid, 0);
            end
            if (hs) begin
                if (bus.o_data !== word(words) || bus.o_last !== (words == N / 4 - 1)) derr++;
                if (words == 0) w0 = bus.o_data;
                wl = bus.o_data;
                if (bus.o_last) last_hs = cyc;
                words++;
            end
            if (tail > 0) tail--;
            else if (tail < 0 && dones + aborts > 0) tail = 20;
            @(posedge clk);
            #1;
            cyc++;
            if (v.abort_at >= 0 && words == v.abort_at && abort_cyc < 0) begin
                fv = 1'b0;
                abort_cyc = cyc;
            end
            if (v.mode == 1 && words >= 1 && !stalled) begin
                stalled = 1'b1;
                stall_left = 20;
            end
            bus.i_ready = v.mode == 2 ? 1'($urandom_range(0, 1)) : stall_left == 0;
            if (stall_left > 0) stall_left--;
        end
        check($sformatf("v%0d_finished_in_budget", i), tail == 0, 1);
        check($sformatf("v%0d_first_valid_latency", i), lat, 6);
        check($sformatf("v%0d_words", i), words, v.words);
        check($sformatf("v%0d_word0", i), w0, v.w0);
        check($sformatf("v%0d_last_word", i), wl, v.wl);
        check($sformatf("v%0d_frame_done_count", i), dones, v.dones);
        check($sformatf("v%0d_abort_count", i), aborts, v.aborts);
        check($sformatf("v%0d_addr_order_errors", i), aerr, 0);
        check($sformatf("v%0d_data_errors", i), derr, 0);
        check($sformatf("v%0d_stability_errors", i), serr, 0);
        check($sformatf("v%0d_commit_limit_errors", i), cerr, 0);
        if (v.reads >= 0) check($sformatf("v%0d_reads", i), reads, v.reads);
        if (v.dones > 0) check($sformatf("v%0d_done_gap", i), gap, 1);
        if (v.mode == 1) check($sformatf("v%0d_stall_max_addr", i), stall_max, v.stall_addr);
    endtask

    initial begin
        int hold;
        int idle;
        int k;
        vecs[0] = '{0, -1, 0, 512, 32'h03020100, 32'hFFFEFDFC, 1, 0, N, -1};
        vecs[1] = '{1, -1, 1, 512, 32'h03020100, 32'h06050403, 1, 0, N, 14};
        vecs[2] = '{2, -1, 3, 512, 32'h03020100, 32'h14131211, 1, 0, N, -1};
        vecs[3] = '{0, 100, 0, 100, 32'h03020100, 32'h8F8E8D8C, 0, 1, -1, -1};
        vecs[4] = '{0, -1, 2, 512, 32'h03020100, 32'h0D0C0B0A, 1, 0, N, -1};
        bus.i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs(), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++)
            run_vec(i);
        hold = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.bram_rd_en || busy) hold++;
        end
        check("held_high_no_restart", hold, 0);
        run_vec(0);
        fv = 1'b0;
        @(posedge clk);
        #1 fv = 1'b1;
        for (k = 0; k < 50 && !bus.o_valid; k++)
            @(negedge clk);
        check("mid_read_busy_valid", {busy, bus.o_valid}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", outs(), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.bram_rd_en || busy) idle++;
        end
        check("post_reset_idle", idle, 0);
        run_vec(0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
